// File: rtl/ev_loader_pkg.sv
// ev_loader_pkg: shared types for the execution environment fill stage.
// Header layout, region sizes and loader FSM states.
package ev_loader_pkg;

    localparam int EV_PRIV_WORDS   = 16;
    localparam int EV_SHARED_WORDS = 4;

    typedef struct packed {
        logic        shared_sel;
        logic        clear_first;
        logic [13:0] reserved;
        logic [7:0]  count;
        logic [7:0]  base;
    } ev_hdr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        ERR   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/ev_hdr_check.sv
// ev_hdr_check: combinational decode of a loader header word.
// Produces region size, out-of-range and zero-count flags.
module ev_hdr_check
    import ev_loader_pkg::*;
#(
    parameter int PRIV_WORDS   = EV_PRIV_WORDS,
    parameter int SHARED_WORDS = EV_SHARED_WORDS
) (
    input  ev_hdr_t    i_hdr,
    output logic [8:0] o_region,
    output logic       o_range_err,
    output logic       o_zero_cnt
);

    logic [8:0] w_end;
    logic [8:0] w_region;
    logic       w_unused_rsvd;

    // 9-bit sum so base+count can never wrap past the region size
    assign w_end       = {1'b0, i_hdr.base} + {1'b0, i_hdr.count};
    assign w_region    = i_hdr.shared_sel ? 9'(SHARED_WORDS) : 9'(PRIV_WORDS);
    assign o_region    = w_region;
    assign o_range_err = w_end > w_region;
    assign o_zero_cnt  = i_hdr.count == 8'd0;

    assign w_unused_rsvd = ^{i_hdr.reserved, i_hdr.clear_first};

endmodule

// File: rtl/ev_loader.sv
// ev_loader: parses header+payload word packets and writes them
// into the private or shared execution environment word regions.
module ev_loader
    import ev_loader_pkg::*;
#(
    parameter int PRIV_WORDS   = EV_PRIV_WORDS,
    parameter int SHARED_WORDS = EV_SHARED_WORDS,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              ev_we,
    output logic              ev_shared,
    output logic [ADDR_W-1:0] ev_addr,
    output logic [31:0]       ev_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_CLEAR = CLEAR;
    localparam logic [1:0] S_LOAD  = LOAD;
    localparam logic [1:0] S_ERR   = ERR;

    logic [1:0]        r_state;
    logic [7:0]        r_base;
    logic [7:0]        r_count;
    logic [7:0]        r_cnt;
    logic [8:0]        r_region;
    logic              r_we;
    logic              r_shared;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic              r_err;

    ev_hdr_t    w_hdr;
    logic [8:0] w_region;
    logic       w_range_err;
    logic       w_zero_cnt;
    logic       w_acc;
    logic       w_final;
    logic       w_clr_end;
    logic [8:0] w_addr9;

    assign w_hdr = s_data;

    ev_hdr_check #(
        .PRIV_WORDS  (PRIV_WORDS),
        .SHARED_WORDS(SHARED_WORDS)
    ) u_hdr_check (
        .i_hdr      (w_hdr),
        .o_region   (w_region),
        .o_range_err(w_range_err),
        .o_zero_cnt (w_zero_cnt)
    );

    assign s_ready   = r_state != S_CLEAR;
    assign w_acc     = s_valid && s_ready;
    assign w_final   = r_cnt == (r_count - 8'd1);
    assign w_clr_end = {1'b0, r_cnt} == (r_region - 9'd1);
    assign w_addr9   = {1'b0, r_base} + {1'b0, r_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_count  <= '0;
            r_cnt    <= '0;
            r_region <= '0;
            r_we     <= 1'b0;
            r_shared <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_shared <= w_hdr.shared_sel;
                        r_base   <= w_hdr.base;
                        r_count  <= w_hdr.count;
                        r_region <= w_region;
                        r_cnt    <= '0;
                        if (w_range_err) begin
                            if (s_last) r_err <= 1'b1;
                            else        r_state <= S_ERR;
                        end else if (w_zero_cnt) begin
                            if (s_last) r_done <= 1'b1;
                            else        r_state <= S_ERR;
                        end else if (w_hdr.clear_first) begin
                            r_state <= S_CLEAR;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_CLEAR: begin
                    r_we    <= 1'b1;
                    r_addr  <= ADDR_W'(r_cnt);
                    r_wdata <= '0;
                    if (w_clr_end) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_LOAD: begin
                    if (w_acc) begin
                        r_we    <= 1'b1;
                        r_addr  <= ADDR_W'(w_addr9);
                        r_wdata <= s_data;
                        r_cnt   <= r_cnt + 8'd1;
                        if (w_final) begin
                            if (s_last) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_ERR;
                            end
                        end else if (s_last) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_ERR: begin
                    if (w_acc && s_last) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ev_we     = r_we;
    assign ev_shared = r_shared;
    assign ev_addr   = r_addr;
    assign ev_wdata  = r_wdata;
    assign done      = r_done;
    assign err       = r_err;
    // busy spans the completion pulse even though the FSM is already idle
    assign busy      = (r_state != S_IDLE) || r_done || r_err;

endmodule

// File: tb/tb_ev_loader.sv
// tb_ev_loader: directed and randomized checks of ev_loader against
// a packet-level reference model.
module tb_ev_loader;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        ev_we;
    logic        ev_shared;
    logic [7:0]  ev_addr;
    logic [31:0] ev_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall = 0;
    int exp_stall = 0;
    int ready_lo = 0;

    logic [40:0] got_w[$];
    int          got_wc[$];
    int          got_ev[$];
    int          got_evc[$];
    logic [40:0] exp_w[$];
    int          exp_ev[$];

    ev_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .ev_we    (ev_we),
        .ev_shared(ev_shared),
        .ev_addr  (ev_addr),
        .ev_wdata (ev_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ev_we) begin
                got_w.push_back({ev_shared, ev_addr, ev_wdata});
                got_wc.push_back(cyc);
            end
            if (done) begin
                got_ev.push_back(1);
                got_evc.push_back(cyc);
            end
            if (err) begin
                got_ev.push_back(2);
                got_evc.push_back(cyc);
            end
            if (!s_ready) ready_lo++;
            if (done || err) begin
                checks++;
                if (done && err) begin
                    errors++;
                    $display("FAIL done_err_overlap got both high at cycle %0d", cyc);
                end
                if (!busy) begin
                    errors++;
                    $display("FAIL busy_pulse got busy=0 exp 1 at cycle %0d", cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic clr();
        got_w.delete();
        got_wc.delete();
        got_ev.delete();
        got_evc.delete();
        exp_w.delete();
        exp_ev.delete();
        stall = 0;
        exp_stall = 0;
        ready_lo = 0;
    endtask

    task automatic send_word(input logic [31:0] d, input bit l);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got s_ready=0 exp 1");
        end
        stall += t;
        @(negedge clk);
    endtask

    // Expected writes/outcome for one packet, from the packet rules only
    task automatic model_pkt(input logic [31:0] hdr, input logic [31:0] pl[$]);
        int r;
        int cnt;
        int base;
        r    = hdr[31] ? 4 : 16;
        cnt  = int'(hdr[15:8]);
        base = int'(hdr[7:0]);
        if (base + cnt > r) begin
            exp_ev.push_back(2);
        end else if (cnt == 0) begin
            exp_ev.push_back(pl.size() == 0 ? 1 : 2);
        end else begin
            if (hdr[30]) begin
                for (int a = 0; a < r; a++)
                    exp_w.push_back({hdr[31], 8'(a), 32'h0});
                exp_stall += r;
            end
            for (int j = 0; j < pl.size() && j < cnt; j++)
                exp_w.push_back({hdr[31], 8'(base + j), pl[j]});
            exp_ev.push_back(pl.size() == cnt ? 1 : 2);
        end
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] pl[$]);
        send_word(hdr, pl.size() == 0);
        for (int i = 0; i < pl.size(); i++)
            send_word(pl[i], i == pl.size() - 1);
        model_pkt(hdr, pl);
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_drain got busy=1 exp 0", nm);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({s_ready, ev_we, ev_shared, ev_addr, ev_wdata, busy, done, err}
            !== {1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b we=%0b sh=%0b a=%0h d=%0h b=%0b dn=%0b er=%0b exp rdy=1 rest 0",
                     s_ready, ev_we, ev_shared, ev_addr, ev_wdata, busy, done, err);
        end
    endtask

    task automatic test_basic_load();
        logic [31:0] pl[$];
        clr();
        pl = '{32'd10, 32'd14};
        send_pkt(32'h0000_0200, pl);
        drain("basic");
        checks++;
        if (got_w.size() !== 2 || got_ev.size() !== 1) begin
            errors++;
            $display("FAIL basic_count got w=%0d ev=%0d exp w=2 ev=1", got_w.size(), got_ev.size());
        end else begin
            checks++;
            if (got_w[0] !== {1'b0, 8'd0, 32'd10} || got_w[1] !== {1'b0, 8'd1, 32'd14}) begin
                errors++;
                $display("FAIL basic_data got %0h %0h exp 0000000a at 0, 0000000e at 1", got_w[0], got_w[1]);
            end
            checks++;
            if (got_wc[1] !== got_wc[0] + 1 || got_ev[0] !== 1 || got_evc[0] !== got_wc[1]) begin
                errors++;
                $display("FAIL basic_timing got wc=%0d,%0d ev=%0d@%0d exp consecutive, done with 2nd write",
                         got_wc[0], got_wc[1], got_ev[0], got_evc[0]);
            end
        end
    endtask

    task automatic test_clear();
        logic [31:0] pl[$];
        int bad;
        clr();
        pl = '{32'd1780};
        send_pkt(32'h4000_0100, pl);
        drain("clear");
        bad = 0;
        checks++;
        if (got_w.size() !== 17) begin
            errors++;
            $display("FAIL clear_count got %0d exp 17", got_w.size());
        end else begin
            for (int a = 0; a < 16; a++)
                if (got_w[a] !== {1'b0, 8'(a), 32'h0}) bad++;
            checks++;
            if (bad !== 0 || got_w[16] !== {1'b0, 8'd0, 32'd1780}) begin
                errors++;
                $display("FAIL clear_data got %0d bad zeros, last=%0h exp 0 bad, last=000000006f4", bad, got_w[16]);
            end
            checks++;
            if (got_ev.size() !== 1 || got_evc[0] !== got_wc[16]) begin
                errors++;
                $display("FAIL clear_done got ev=%0d exp one done with final write", got_ev.size());
            end
        end
        checks++;
        if (ready_lo !== 16 || stall !== 16) begin
            errors++;
            $display("FAIL clear_ready got lo=%0d stall=%0d exp 16 16", ready_lo, stall);
        end
    endtask

    task automatic test_shared();
        logic [31:0] pl[$];
        clr();
        pl = '{32'd65};
        send_pkt(32'h8000_0100, pl);
        drain("shared");
        checks++;
        if (got_w.size() !== 1 || got_ev.size() !== 1) begin
            errors++;
            $display("FAIL shared_count got w=%0d ev=%0d exp 1 1", got_w.size(), got_ev.size());
        end else if (got_w[0] !== {1'b1, 8'd0, 32'd65} || got_ev[0] !== 1) begin
            errors++;
            $display("FAIL shared_write got %0h ev=%0d exp 10000000041 ev=1", got_w[0], got_ev[0]);
        end
    endtask

    task automatic test_range_err();
        logic [31:0] pl[$];
        clr();
        pl = '{32'd3, 32'd4};
        send_pkt(32'h0000_0210, pl);
        drain("range");
        checks++;
        if (got_w.size() !== 0 || got_ev.size() !== 1) begin
            errors++;
            $display("FAIL range_err got w=%0d ev=%0d exp 0 1", got_w.size(), got_ev.size());
        end else if (got_ev[0] !== 2) begin
            errors++;
            $display("FAIL range_kind got %0d exp 2(err)", got_ev[0]);
        end
    endtask

    task automatic test_short_long();
        logic [31:0] pa[$];
        logic [31:0] pb[$];
        clr();
        pa = '{32'd1, 32'd2};
        pb = '{32'd7, 32'd8, 32'd9};
        send_pkt(32'h0000_0300, pa);
        drain("short");
        send_pkt(32'h0000_0100, pb);
        drain("long");
        checks++;
        if (got_w.size() !== 3 || got_ev.size() !== 2) begin
            errors++;
            $display("FAIL shortlong_count got w=%0d ev=%0d exp 3 2", got_w.size(), got_ev.size());
        end else begin
            checks++;
            if (got_w[0] !== {1'b0, 8'd0, 32'd1} || got_w[1] !== {1'b0, 8'd1, 32'd2} ||
                got_w[2] !== {1'b0, 8'd0, 32'd7}) begin
                errors++;
                $display("FAIL shortlong_data got %0h %0h %0h exp 1@0 2@1 7@0", got_w[0], got_w[1], got_w[2]);
            end
            checks++;
            if (got_ev[0] !== 2 || got_ev[1] !== 2 || got_evc[0] !== got_wc[1]) begin
                errors++;
                $display("FAIL shortlong_err got ev=%0d,%0d exp 2,2 short err with its write", got_ev[0], got_ev[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa[$];
        logic [31:0] pb[$];
        clr();
        pa = '{32'd5};
        pb = '{32'd6};
        send_pkt(32'h0000_0100, pa);
        send_pkt(32'h8000_0101, pb);
        drain("b2b");
        checks++;
        if (got_w.size() !== 2 || got_ev.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count got w=%0d ev=%0d exp 2 2", got_w.size(), got_ev.size());
        end else if (got_w[0] !== {1'b0, 8'd0, 32'd5} || got_w[1] !== {1'b1, 8'd1, 32'd6} ||
                     got_wc[1] !== got_wc[0] + 2 || got_ev[0] !== 1 || got_ev[1] !== 1) begin
            errors++;
            $display("FAIL b2b_data got %0h@%0d %0h@%0d exp 5@0 then shared 6@1 two cycles later",
                     got_w[0], got_wc[0], got_w[1], got_wc[1]);
        end
        checks++;
        if (stall !== 0) begin
            errors++;
            $display("FAIL b2b_stall got %0d exp 0", stall);
        end
    endtask

    task automatic test_random();
        logic [31:0] pl[$];
        logic [31:0] hdr;
        int r;
        int cnt;
        int n;
        int bad;
        clr();
        for (int p = 0; p < 40; p++) begin
            hdr = $urandom;
            hdr[31] = ($urandom_range(0, 3) == 0);
            hdr[30] = ($urandom_range(0, 4) == 0);
            r   = hdr[31] ? 4 : 16;
            cnt = $urandom_range(0, 4);
            hdr[15:8] = 8'(cnt);
            hdr[7:0]  = 8'($urandom_range(0, r));
            n = (cnt == 0) ? $urandom_range(0, 1) : $urandom_range(1, cnt + 1);
            pl.delete();
            for (int j = 0; j < n; j++) pl.push_back($urandom);
            send_pkt(hdr, pl);
        end
        drain("random");
        bad = 0;
        checks++;
        if (got_w.size() !== exp_w.size()) begin
            errors++;
            $display("FAIL rand_wcount got %0d exp %0d", got_w.size(), exp_w.size());
        end else begin
            for (int i = 0; i < exp_w.size(); i++)
                if (got_w[i] !== exp_w[i]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL rand_wdata got %0d mismatched writes exp 0", bad);
            end
        end
        bad = 0;
        checks++;
        if (got_ev.size() !== exp_ev.size()) begin
            errors++;
            $display("FAIL rand_evcount got %0d exp %0d", got_ev.size(), exp_ev.size());
        end else begin
            for (int i = 0; i < exp_ev.size(); i++)
                if (got_ev[i] !== exp_ev[i]) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL rand_events got %0d mismatched outcomes exp 0", bad);
            end
        end
        checks++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL rand_stall got %0d exp %0d", stall, exp_stall);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] pl[$];
        int t;
        clr();
        send_word(32'h4000_0100, 1'b0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        t = 0;
        while (!(ev_we && ev_addr == 8'd5) && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!(ev_we && ev_addr == 8'd5)) begin
            errors++;
            $display("FAIL rst_reach got we=%0b a=%0h exp write at 5", ev_we, ev_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ev_we, busy, s_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rst_abort got we=%0b busy=%0b rdy=%0b exp 0 0 1", ev_we, busy, s_ready);
        end
        clr();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pl = '{32'h0000_00ab};
        send_pkt(32'h0000_0100, pl);
        drain("rstpkt");
        checks++;
        if (got_w.size() !== 1 || got_ev.size() !== 1) begin
            errors++;
            $display("FAIL rst_next_count got w=%0d ev=%0d exp 1 1", got_w.size(), got_ev.size());
        end else if (got_w[0] !== {1'b0, 8'd0, 32'h0000_00ab} || got_ev[0] !== 1) begin
            errors++;
            $display("FAIL rst_next_data got %0h ev=%0d exp 000000000ab ev=1", got_w[0], got_ev[0]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_load();
        test_clear();
        test_shared();
        test_range_err();
        test_short_long();
        test_back_to_back();
        test_random();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
